// File: rtl/wfifo_sync_if.sv
// Write-data FIFO port bundle: cmd_decode/SDRAM side handshake, status and debug flags.
interface wfifo_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   data_count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, data_count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, data_count, overflow, underflow
    );
endinterface

// File: rtl/wfifo_sync.sv
// Synchronous write-data FIFO between cmd_decode and the SDRAM write controller,
// with registered read port, occupancy count, full/empty and sticky error flags.
module wfifo_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic        sclk,
    input logic        reset,
    wfifo_sync_if.slave fif
);
    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_n;
    logic              full_r;
    logic              empty_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              wr_acc;
    logic              rd_acc;

    // Accept decisions use the registered flags, so a simultaneous read never
    // frees space for a write in the same cycle (and vice versa).
    always_comb begin
        wr_acc  = fif.wr_en & ~full_r;
        rd_acc  = fif.rd_en & ~empty_r;
        count_n = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_n = count + CNT_ONE;
            2'b01:   count_n = count - CNT_ONE;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= fif.wr_data;
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            rd_data_r   <= '0;
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                rd_data_r <= mem[rd_ptr];
            end
            rd_valid_r <= rd_acc;
            count      <= count_n;
            full_r     <= (count_n == DEPTH);
            empty_r    <= (count_n == '0);
            if (fif.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
            if (fif.rd_en && empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign fif.rd_data    = rd_data_r;
    assign fif.rd_valid   = rd_valid_r;
    assign fif.full       = full_r;
    assign fif.empty      = empty_r;
    assign fif.data_count = count;
    assign fif.overflow   = overflow_r;
    assign fif.underflow  = underflow_r;
endmodule

// File: tb/tb_wfifo_sync.sv
// Bench for wfifo_sync: directed plan steps plus random traffic, checked every
// cycle against a queue-based reference model.
module tb_wfifo_sync;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic sclk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_rd_data;
    logic       exp_rd_valid;
    logic       exp_ovf;
    logic       exp_udf;

    wfifo_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

    wfifo_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .sclk  (sclk),
        .reset (reset),
        .fif   (fif.slave)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_valid"},   32'(fif.rd_valid),   32'(exp_rd_valid));
        check({tag, ".rd_data"},    32'(fif.rd_data),    32'(exp_rd_data));
        check({tag, ".data_count"}, 32'(fif.data_count), 32'(model_q.size()));
        check({tag, ".full"},       32'(fif.full),       32'(model_q.size() == DEPTH));
        check({tag, ".empty"},      32'(fif.empty),      32'(model_q.size() == 0));
        check({tag, ".overflow"},   32'(fif.overflow),   32'(exp_ovf));
        check({tag, ".underflow"},  32'(fif.underflow),  32'(exp_udf));
    endtask

    // One clock with the given inputs; model acts on pre-edge occupancy.
    task automatic cycle(input string tag, input bit we, input logic [7:0] wd, input bit re);
        bit wacc, racc;
        fif.wr_en   = we;
        fif.wr_data = wd;
        fif.rd_en   = re;
        wacc = we && (model_q.size() != DEPTH);
        racc = re && (model_q.size() != 0);
        exp_rd_valid = racc;
        if (racc) exp_rd_data = model_q.pop_front();
        if (wacc) model_q.push_back(wd);
        if (we && !wacc) exp_ovf = 1'b1;
        if (re && !racc) exp_udf = 1'b1;
        @(posedge sclk);
        #1;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b1;
        fif.wr_en   = 1'b0;
        fif.rd_en   = 1'b0;
        fif.wr_data = '0;
        model_q.delete();
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
        @(posedge sclk);
        #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] basic [4];
        basic[0] = 8'h12; basic[1] = 8'h34; basic[2] = 8'h56; basic[3] = 8'h78;

        // 1: basic ordering
        do_reset("reset");
        for (int i = 0; i < 4; i++) cycle("basic_wr", 1'b1, basic[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle("basic_rd", 1'b0, 8'h00, 1'b1);
            check("basic_rd_word", 32'(fif.rd_data), 32'(basic[i]));
        end

        // 2: fill and overflow
        do_reset("reset2");
        for (int i = 0; i < 16; i++) cycle("fill_wr", 1'b1, 8'(i), 1'b0);
        check("fill_full", 32'(fif.full), 32'd1);
        cycle("ovf_wr", 1'b1, 8'hAA, 1'b0);
        check("ovf_flag", 32'(fif.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle("fill_rd", 1'b0, 8'h00, 1'b1);
            check("fill_rd_word", 32'(fif.rd_data), 32'(i));
        end

        // 3: underflow from reset
        do_reset("reset3");
        cycle("udf_rd", 1'b0, 8'h00, 1'b1);
        check("udf_flag", 32'(fif.underflow), 32'd1);

        // 4: wrap-around over three rounds
        do_reset("reset4");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) cycle("wrap_wr", 1'b1, 8'(8'h40 + r*10 + i), 1'b0);
            for (int i = 0; i < 10; i++) cycle("wrap_rd", 1'b0, 8'h00, 1'b1);
        end

        // 5: simultaneous read/write at mid, full and empty
        do_reset("reset5");
        for (int i = 0; i < 5; i++) cycle("sim_pre", 1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle("sim_mid", 1'b1, 8'(8'hB0 + i), 1'b1);
        for (int i = 0; i < 11; i++) cycle("sim_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle("sim_full", 1'b1, 8'hEE, 1'b1);
        check("sim_full_count", 32'(fif.data_count), 32'd15);
        for (int i = 0; i < 15; i++) cycle("sim_drain", 1'b0, 8'h00, 1'b1);
        cycle("sim_empty", 1'b1, 8'hDD, 1'b1);
        check("sim_empty_count", 32'(fif.data_count), 32'd1);

        // 6: reset mid-operation
        do_reset("reset6");
        cycle("mid_wr", 1'b1, 8'h55, 1'b0);
        cycle("mid_wr", 1'b1, 8'h12, 1'b0);
        cycle("mid_wr", 1'b1, 8'h34, 1'b0);
        do_reset("mid_reset");
        cycle("mid_rd", 1'b0, 8'h00, 1'b1);

        // random traffic, write-biased then read-biased phases
        do_reset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            int unsigned wb;
            wb = (i % 200 < 100) ? 70 : 30;
            cycle("rand", ($urandom_range(99) < wb), 8'($urandom), ($urandom_range(99) < 100 - wb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
